// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
// Defining SEQ_DIVIDER_DBZ_EN turns on divide-by-zero detection. A zero
// divisor then completes in one cycle and raises div_by_zero. With the macro
// left undefined, a zero divisor runs the normal N-step sequence and
// div_by_zero is tied low.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int W1 = N + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N:0]    rem_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    r_shift;
  logic [N:0]    r_next;
  logic          q_bit;
  logic [N-1:0]  dvd_next;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // One restoring step: bring in the next dividend bit, trial-subtract the
  // divisor, and shift the resulting quotient bit into the vacated LSB.
  always_comb begin
    r_shift = (rem_q << 1) | W1'(dvd_q[N-1]);
    r_next  = r_shift;
    q_bit   = 1'b0;
    if (r_shift >= {1'b0, dvs_q}) begin
      r_next = r_shift - {1'b0, dvs_q};
      q_bit  = 1'b1;
    end
    dvd_next = (dvd_q << 1) | N'(q_bit);
  end

`ifdef SEQ_DIVIDER_DBZ_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  // FSM and datapath. Results only load on the way into DONE, so the outputs
  // keep the last answer for the whole of the next operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= CNT_N;
`ifdef SEQ_DIVIDER_DBZ_EN
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dbz_q     <= 1'b1;
              state     <= DONE;
            end else begin
              state <= OP;
            end
`else
            state <= OP;
`endif
          end
        end
        OP: begin
          dvd_q <= dvd_next;
          rem_q <= r_next;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            quotient  <= dvd_next;
            remainder <= r_next[N-1:0];
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz_q     <= 1'b0;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
